// File: rtl/bus1_arbiter.sv
// Two-port round-robin arbiter that serialises held requests onto the cache's
// CPU-side C1/A1/D1 bus and returns one 32-bit result to the granted port.
module bus1_arbiter #(
   parameter int CACHE_TAG_SIZE    = 10,
   parameter int CACHE_SET_SIZE    = 4,
   parameter int CACHE_OFFSET_SIZE = 4,
   parameter int ADDR1_BUS_SIZE    = 14,
   parameter int DATA_BUS_SIZE     = 16,
   parameter int TIMEOUT_CYCLES    = 1023
) (
   input  logic                                                       CLK,
   input  logic                                                       RESET,
   input  logic [2:0]                                                 P0_CMD,
   input  logic [CACHE_TAG_SIZE+CACHE_SET_SIZE+CACHE_OFFSET_SIZE-1:0] P0_ADDR,
   input  logic [31:0]                                                P0_WDATA,
   input  logic [2:0]                                                 P1_CMD,
   input  logic [CACHE_TAG_SIZE+CACHE_SET_SIZE+CACHE_OFFSET_SIZE-1:0] P1_ADDR,
   input  logic [31:0]                                                P1_WDATA,
   output logic                                                       P0_RSP_VALID,
   output logic [31:0]                                                P0_RSP_DATA,
   output logic                                                       P0_RSP_ERR,
   output logic                                                       P1_RSP_VALID,
   output logic [31:0]                                                P1_RSP_DATA,
   output logic                                                       P1_RSP_ERR,
   output logic [1:0]                                                 GRANT,
   output logic [2:0]                                                 C1_OUT,
   output logic [ADDR1_BUS_SIZE-1:0]                                  A1_OUT,
   output logic [DATA_BUS_SIZE-1:0]                                   D1_OUT,
   output logic                                                       BUS1_OE,
   input  logic [2:0]                                                 C1_IN,
   input  logic [DATA_BUS_SIZE-1:0]                                   D1_IN
);

   localparam int ADDR_W = CACHE_TAG_SIZE + CACHE_SET_SIZE + CACHE_OFFSET_SIZE;
   localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ADDR1 = 3'd1;
   localparam logic [2:0] ADDR2 = 3'd2;
   localparam logic [2:0] WAIT  = 3'd3;
   localparam logic [2:0] RESP2 = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   localparam logic [2:0] CMD_NOP     = 3'd0;
   localparam logic [2:0] CMD_READ8   = 3'd1;
   localparam logic [2:0] CMD_READ16  = 3'd2;
   localparam logic [2:0] CMD_READ32  = 3'd3;
   localparam logic [2:0] CMD_WRITE8  = 3'd5;
   localparam logic [2:0] CMD_WRITE32 = 3'd7;
   localparam logic [2:0] C1_RESPONSE = 3'd7;

   logic [2:0]        state;
   logic              owner;
   logic              last_grant;
   logic [2:0]        cmd_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       result_q;
   logic              err_q;
   logic [CNT_W-1:0]  cnt;

   logic        req0;
   logic        req1;
   logic        pick;
   logic        is_write;
   logic [31:0] rsp_data;

   // A tie goes to the port that did not own the previous transaction.
   assign req0     = (P0_CMD != CMD_NOP);
   assign req1     = (P1_CMD != CMD_NOP);
   assign pick     = (req0 && req1) ? ~last_grant : req1;
   assign is_write = (cmd_q >= CMD_WRITE8);

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         cmd_q      <= CMD_NOP;
         addr_q     <= '0;
         wdata_q    <= '0;
         result_q   <= '0;
         err_q      <= 1'b0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner    <= pick;
                  cmd_q    <= pick ? P1_CMD   : P0_CMD;
                  addr_q   <= pick ? P1_ADDR  : P0_ADDR;
                  wdata_q  <= pick ? P1_WDATA : P0_WDATA;
                  result_q <= '0;
                  err_q    <= 1'b0;
                  state    <= ADDR1;
               end
            end
            ADDR1: state <= ADDR2;
            ADDR2: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               // A real response wins over a timeout landing on the same edge.
               if (C1_IN == C1_RESPONSE) begin
                  result_q[15:0] <= D1_IN;
                  state          <= (cmd_q == CMD_READ32) ? RESP2 : DONE;
               end else if (cnt == CNT_MAX) begin
                  err_q    <= 1'b1;
                  result_q <= '0;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP2: begin
               result_q[31:16] <= D1_IN;
               state           <= DONE;
            end
            DONE: begin
               last_grant <= owner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rsp_data = 32'd0;
      case (cmd_q)
         CMD_READ8:  rsp_data = {24'd0, result_q[7:0]};
         CMD_READ16: rsp_data = {16'd0, result_q[15:0]};
         CMD_READ32: rsp_data = result_q;
         default:    rsp_data = 32'd0;
      endcase
   end

   // Bus and response outputs are a pure decode of the current phase.
   always_comb begin
      GRANT        = 2'b00;
      BUS1_OE      = 1'b0;
      C1_OUT       = CMD_NOP;
      A1_OUT       = '0;
      D1_OUT       = '0;
      P0_RSP_VALID = 1'b0;
      P0_RSP_DATA  = 32'd0;
      P0_RSP_ERR   = 1'b0;
      P1_RSP_VALID = 1'b0;
      P1_RSP_DATA  = 32'd0;
      P1_RSP_ERR   = 1'b0;
      if (state != IDLE) begin
         GRANT = owner ? 2'b10 : 2'b01;
      end
      case (state)
         ADDR1: begin
            BUS1_OE = 1'b1;
            C1_OUT  = cmd_q;
            A1_OUT  = addr_q[ADDR_W-1:CACHE_OFFSET_SIZE];
            D1_OUT  = is_write ? wdata_q[15:0] : 16'd0;
         end
         ADDR2: begin
            BUS1_OE = 1'b1;
            A1_OUT  = ADDR1_BUS_SIZE'(addr_q[CACHE_OFFSET_SIZE-1:0]);
            D1_OUT  = (cmd_q == CMD_WRITE32) ? wdata_q[31:16] : 16'd0;
         end
         DONE: begin
            if (owner) begin
               P1_RSP_VALID = 1'b1;
               P1_RSP_DATA  = rsp_data;
               P1_RSP_ERR   = err_q;
            end else begin
               P0_RSP_VALID = 1'b1;
               P0_RSP_DATA  = rsp_data;
               P0_RSP_ERR   = err_q;
            end
         end
         default: ;
      endcase
   end

endmodule
